tdest_inserter: RTL and testbench
=================================

Name: tdest_inserter

Overview:
- MM2S-direction counterpart of the S2MM tdest classifier.
- Accepts AXI4-Stream packets that carry a sideband TDEST from the MM2S DMA / switch.
- Writes the TDEST into the header field of each packet's first beat, at data bits [TDATA_WIDTH-2 : TDATA_WIDTH-TDEST_WIDTH-1]. This is the same field the S2MM classifier decodes, so a loopback recovers the original TDEST.
- Drops the sideband TDEST on the output and registers the stream through a skid buffer at full throughput.

Parameters:
- TDEST_WIDTH, 4, sideband destination width and header field width.
- TDATA_WIDTH, 64, stream data width; must be at least TDEST_WIDTH+2 and a multiple of 8.
- TKEEP_WIDTH, TDATA_WIDTH/8, keep width.

Ports:
- clk  in  1  stream clock
- reset  in  1  asynchronous, active-high reset
- s_axis_mm2s_tvalid  in  1  input beat valid
- s_axis_mm2s_tready  out  1  input ready
- s_axis_mm2s_tdata  in  TDATA_WIDTH  input data
- s_axis_mm2s_tkeep  in  TKEEP_WIDTH  input byte enables
- s_axis_mm2s_tlast  in  1  end of packet
- s_axis_mm2s_tuser  in  1  user bit, passed through
- s_axis_mm2s_tdest  in  TDEST_WIDTH  packet destination
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  TDATA_WIDTH  data, header field inserted on first beat
- m_axis_tkeep  out  TKEEP_WIDTH  byte enables
- m_axis_tlast  out  1  end of packet
- m_axis_tuser  out  1  user bit
- tdest_err  out  1  sticky flag: TDEST changed inside a packet
- err_clear  in  1  synchronous clear of tdest_err

Behaviour:
- Reset values: m_axis_tvalid=0, s_axis_mm2s_tready=0, tdest_err=0, FSM=SOP, skid buffer empty, m_axis data/keep/last/user=0.
- s_axis_mm2s_tready rises on the first clk edge after reset deasserts.
- Accept: a beat transfers when s_axis_mm2s_tvalid && s_axis_mm2s_tready.
- Latency: 1 cycle from input accept to m_axis_tvalid. Throughput is 1 beat/cycle under continuous m_axis_tready.
- Skid buffer: 2 entries (output register + skid register).
  - s_axis_mm2s_tready = skid entry empty, registered.
  - When m_axis_tready drops with a beat already in flight, that beat parks in the skid entry; no beat is lost or duplicated.
  - m_axis_* stay stable while m_axis_tvalid && !m_axis_tready (AXIS rule).
- FSM (updates on accepted beats only):
  - SOP: the accepted beat is the first beat. Latch tdest_q <= s_axis_mm2s_tdest. Data bits [TDATA_WIDTH-2 : TDATA_WIDTH-TDEST_WIDTH-1] are replaced by s_axis_mm2s_tdest; all other bits, including the MSB, are unchanged. If tlast=1, stay in SOP (single-beat packet); else go to MID.
  - MID: data passes unmodified. If s_axis_mm2s_tdest != tdest_q, set tdest_err. If tlast=1, go to SOP.
- tdest_err:
  - Sticky; cleared by err_clear on the next edge.
  - If err_clear coincides with a new mismatch, set wins.
  - The mismatch has no effect on output data.
- tkeep, tuser and tlast pass through on every beat.
- Asynchronous reset mid-packet: the FSM returns to SOP and both buffer entries are discarded. The next accepted beat after reset is treated as a first beat. Downstream sees m_axis_tvalid drop immediately, which yields a truncated packet with no tlast; this is accepted behaviour.
- Idle cycles (tvalid=0) inside a packet do not change FSM state.

Optional Feature:
- Macro: TDEST_INSERTER_STATS_EN.
- When defined, the block adds output pkt_cnt [31:0]:
  - Increments when a beat with tlast=1 is accepted on the output side (m_axis_tvalid && m_axis_tready && m_axis_tlast).
  - Wraps 0xFFFF_FFFF -> 0.
  - Reset value 0; cleared by err_clear.
- When undefined, the port and counter are absent and all other behaviour is identical.

Decomposition:
- Shared package tdest_pkg:
  - state typedef {SOP, MID};
  - default TDEST_WIDTH/TDATA_WIDTH constants;
  - field-position constants TDEST_HI=TDATA_WIDTH-2 and TDEST_LO=TDATA_WIDTH-TDEST_WIDTH-1, shared with the S2MM classifier.
- One sub-module, axis_skid_buffer:
  - 2-entry register slice;
  - payload width parameterised (data+keep+last+user).
- The FSM and insertion logic stay in tdest_inserter.

Test Plan (all cases use TDATA_WIDTH=64, TDEST_WIDTH=4, header field = bits [62:59]):
1. Single-beat packet: tdata=64'h0, tdest=4'hA, tlast=1, m_axis_tready=1 -> one cycle later m_axis_tdata=64'h5000_0000_0000_0000, tlast=1, tdest_err=0.
2. 3-beat packet: tdata all ones on every beat, tdest=4'hA -> beat0 = 64'hD7FF_FFFF_FFFF_FFFF; beats 1 and 2 = 64'hFFFF_FFFF_FFFF_FFFF; tkeep/tuser match input; back-to-back packets run with no bubble.
3. Backpressure: continuous input while m_axis_tready toggles 1,0,0,1,… in a random pattern over 100 beats -> output sequence equals input sequence, no loss or duplication, output payload stable while stalled, s_axis_mm2s_tready low at most while the skid entry is full.
4. TDEST change mid-packet: beat0 tdest=3, beat1 tdest=5 -> tdest_err=1 from the following cycle and held. Pulse err_clear -> tdest_err=0. err_clear in the same cycle as a new mismatch -> tdest_err stays 1.
5. Reset asserted after beat 1 of a 4-beat packet -> m_axis_tvalid=0 and tready=0 asynchronously. After release, the next packet (tdest=4'h1, data 64'h0) -> first beat = 64'h0800_0000_0000_0000.
6. With TDEST_INSERTER_STATS_EN defined: send 5 packets of mixed length 1–8 beats -> pkt_cnt=5. Force the count to 0xFFFF_FFFF, then send 1 more packet -> pkt_cnt=0.

Source files
------------

// File: rtl/tdest_pkg.sv
// Types and constants shared by the MM2S tdest inserter and the S2MM tdest classifier.
// Both sides must agree on where the destination header field sits.
package tdest_pkg;

  typedef enum logic {
    SOP = 1'b0,
    MID = 1'b1
  } state_t;

  localparam int DEF_TDEST_WIDTH = 4;
  localparam int DEF_TDATA_WIDTH = 64;

  // Header field position for the default widths; the MSB is left untouched.
  localparam int TDEST_HI = DEF_TDATA_WIDTH - 2;
  localparam int TDEST_LO = DEF_TDATA_WIDTH - DEF_TDEST_WIDTH - 1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream register slice (output register + skid register).
// Full throughput with a registered upstream ready.
module axis_skid_buffer #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [PW-1:0] s_payload,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_payload
);

  logic          out_valid_q;
  logic          out_valid_d;
  logic          skid_valid_q;
  logic          skid_valid_d;
  logic          ready_q;
  logic [PW-1:0] out_q;
  logic [PW-1:0] skid_q;
  logic          accept;
  logic          load_out;

  assign accept   = s_valid && ready_q;
  assign load_out = !out_valid_q || m_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (load_out) begin
      out_valid_d  = skid_valid_q || accept;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      // Ready can only be high when the skid entry is empty, so an accepted
      // beat always has somewhere to go.
      ready_q      <= !skid_valid_d;
      if (load_out && skid_valid_q) begin
        out_q <= skid_q;
      end else if (load_out && accept) begin
        out_q <= s_payload;
      end
      if (!load_out && accept) begin
        skid_q <= s_payload;
      end
    end
  end

  assign s_ready   = ready_q;
  assign m_valid   = out_valid_q;
  assign m_payload = out_q;

endmodule

// File: rtl/tdest_inserter.sv
// Inserts the sideband TDEST into the header field of each packet's first beat.
// Optional TDEST_INSERTER_STATS_EN adds a pkt_cnt output counting delivered packets.
module tdest_inserter
  import tdest_pkg::*;
#(
  parameter int TDEST_WIDTH = DEF_TDEST_WIDTH,
  parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_axis_mm2s_tvalid,
  output logic                   s_axis_mm2s_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_mm2s_tdata,
  input  logic [TKEEP_WIDTH-1:0] s_axis_mm2s_tkeep,
  input  logic                   s_axis_mm2s_tlast,
  input  logic                   s_axis_mm2s_tuser,
  input  logic [TDEST_WIDTH-1:0] s_axis_mm2s_tdest,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   tdest_err,
`ifdef TDEST_INSERTER_STATS_EN
  output logic [31:0]            pkt_cnt,
`endif
  input  logic                   err_clear
);

  localparam int HI = TDATA_WIDTH - 2;
  localparam int LO = TDATA_WIDTH - TDEST_WIDTH - 1;
  localparam int PW = TDATA_WIDTH + TKEEP_WIDTH + 2;

  state_t                 state_q;
  state_t                 state_d;
  logic [TDEST_WIDTH-1:0] tdest_q;
  logic [TDEST_WIDTH-1:0] tdest_d;
  logic                   accept;
  logic                   mismatch;
  logic                   err_q;
  logic [TDATA_WIDTH-1:0] data_ins;
  logic [PW-1:0]          in_payload;
  logic [PW-1:0]          out_payload;

  assign accept = s_axis_mm2s_tvalid && s_axis_mm2s_tready;

  always_comb begin
    state_d  = state_q;
    tdest_d  = tdest_q;
    mismatch = 1'b0;
    data_ins = s_axis_mm2s_tdata;
    if (state_q == SOP) begin
      data_ins[HI:LO] = s_axis_mm2s_tdest;
    end
    if (accept) begin
      case (state_q)
        SOP: begin
          tdest_d = s_axis_mm2s_tdest;
          state_d = s_axis_mm2s_tlast ? SOP : MID;
        end
        MID: begin
          mismatch = (s_axis_mm2s_tdest != tdest_q);
          if (s_axis_mm2s_tlast) begin
            state_d = SOP;
          end
        end
        default: state_d = SOP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SOP;
      tdest_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tdest_q <= tdest_d;
      // A new mismatch outranks a clear in the same cycle.
      if (mismatch) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end
    end
  end

  assign tdest_err  = err_q;
  assign in_payload = {s_axis_mm2s_tuser, s_axis_mm2s_tlast, s_axis_mm2s_tkeep, data_ins};

  axis_skid_buffer #(
    .PW(PW)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_axis_mm2s_tvalid),
    .s_ready  (s_axis_mm2s_tready),
    .s_payload(in_payload),
    .m_valid  (m_axis_tvalid),
    .m_ready  (m_axis_tready),
    .m_payload(out_payload)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_payload;

`ifdef TDEST_INSERTER_STATS_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q <= '0;
    end else if (err_clear) begin
      pkt_cnt_q <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_tdest_inserter.sv
// Self-checking bench for tdest_inserter: directed cases plus randomized traffic
// against a queue-based reference model.
module tb_tdest_inserter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        s_user = 1'b0;
  logic [3:0]  s_dest = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_user;
  logic        tdest_err;
  logic        err_clear = 1'b0;
`ifdef TDEST_INSERTER_STATS_EN
  logic [31:0] pkt_cnt;
`endif

  always #5 clk = ~clk;

  tdest_inserter dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_mm2s_tvalid(s_valid),
    .s_axis_mm2s_tready(s_ready),
    .s_axis_mm2s_tdata (s_data),
    .s_axis_mm2s_tkeep (s_keep),
    .s_axis_mm2s_tlast (s_last),
    .s_axis_mm2s_tuser (s_user),
    .s_axis_mm2s_tdest (s_dest),
    .m_axis_tvalid     (m_valid),
    .m_axis_tready     (m_ready),
    .m_axis_tdata      (m_data),
    .m_axis_tkeep      (m_keep),
    .m_axis_tlast      (m_last),
    .m_axis_tuser      (m_user),
    .tdest_err         (tdest_err),
`ifdef TDEST_INSERTER_STATS_EN
    .pkt_cnt           (pkt_cnt),
`endif
    .err_clear         (err_clear)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected output beats in order, plus packet/error state.
  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       exp_q[$];
  bit          exp_sop = 1'b1;
  logic [3:0]  ref_dest = '0;
  bit          err_exp = 1'b0;
  logic [31:0] pkt_exp = '0;

  // Random driver state
  int          pkt_left = 0;
  logic [3:0]  cur_dest = '0;

  function automatic logic [63:0] with_header(input logic [63:0] d, input logic [3:0] t);
    logic [63:0] r;
    r = d;
    r[62:59] = t;
    return r;
  endfunction

  // One clock: inputs are already driven; observe handshakes, advance model, check.
  task automatic cycle();
    bit          in_fire;
    bit          out_fire;
    bit          new_mismatch;
    bit          stalled;
    logic [73:0] held;
    beat_t       b;
    in_fire      = s_valid && s_ready;
    out_fire     = m_valid && m_ready;
    new_mismatch = 1'b0;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", m_valid, 1'b0);
      end else begin
        b = exp_q.pop_front();
        check_eq("m_tdata", m_data, b.d);
        check_eq("m_tkeep", m_keep, b.k);
        check_eq("m_tlast", m_last, b.l);
        check_eq("m_tuser", m_user, b.u);
      end
    end
    if (in_fire) begin
      b.k = s_keep;
      b.l = s_last;
      b.u = s_user;
      if (exp_sop) begin
        b.d      = with_header(s_data, s_dest);
        ref_dest = s_dest;
      end else begin
        b.d = s_data;
        new_mismatch = (s_dest != ref_dest);
      end
      exp_sop = s_last;
      exp_q.push_back(b);
    end
    if (new_mismatch) err_exp = 1'b1;
    else if (err_clear) err_exp = 1'b0;
    if (err_clear) pkt_exp = '0;
    else if (out_fire && m_last) pkt_exp = pkt_exp + 32'd1;
    stalled = m_valid && !m_ready;
    held    = {m_user, m_last, m_keep, m_data};
    @(posedge clk);
    @(negedge clk);
    check_eq("m_valid", m_valid, exp_q.size() != 0);
    check_eq("s_ready", s_ready, exp_q.size() < 2);
    check_eq("tdest_err", tdest_err, err_exp);
    if (stalled) begin
      check_eq("stall_valid", m_valid, 1'b1);
      check_eq("stall_hold", {m_user, m_last, m_keep, m_data}, held);
    end
`ifdef TDEST_INSERTER_STATS_EN
    check_eq("pkt_cnt", pkt_cnt, pkt_exp);
`endif
  endtask

  task automatic drive(input logic [63:0] d, input logic [3:0] t, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_dest  = t;
    s_last  = l;
    s_keep  = 8'($urandom);
    s_user  = 1'($urandom);
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    m_ready = 1'b1;
    err_clear = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic rand_traffic(input int cycles, input int pv, input int pr, input int pe, input int pc);
    bit first;
    for (int i = 0; i < cycles; i++) begin
      if (!(s_valid && !s_ready)) begin
        s_valid = ($urandom_range(99) < pv);
        if (s_valid) begin
          first = (pkt_left == 0);
          if (first) begin
            pkt_left = $urandom_range(1, 8);
            cur_dest = 4'($urandom);
          end
          pkt_left--;
          s_data = {$urandom, $urandom};
          s_keep = 8'($urandom);
          s_user = 1'($urandom);
          s_last = (pkt_left == 0);
          s_dest = (!first && $urandom_range(99) < pe) ? 4'($urandom) : cur_dest;
        end
      end
      m_ready   = ($urandom_range(99) < pr);
      err_clear = ($urandom_range(99) < pc);
      cycle();
    end
    // finish any open packet with a ready sink
    m_ready   = 1'b1;
    err_clear = 1'b0;
    for (int i = 0; i < 40 && (pkt_left != 0 || (s_valid && !s_ready)); i++) begin
      if (!(s_valid && !s_ready)) begin
        pkt_left--;
        s_valid = 1'b1;
        s_data  = {$urandom, $urandom};
        s_last  = (pkt_left == 0);
        s_dest  = cur_dest;
      end
      cycle();
    end
    check_eq("pkt_closed", pkt_left, 0);
    idle(3);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_s_ready", s_ready, 1'b0);
    check_eq("rst_tdest_err", tdest_err, 1'b0);
    check_eq("rst_m_payload", {m_user, m_last, m_keep, m_data}, 74'd0);
    reset = 1'b0;
    check_eq("ready_before_edge", s_ready, 1'b0);
    m_ready = 1'b1;
    idle(1);

    // Single-beat packet
    drive(64'h0, 4'hA, 1'b1);
    check_eq("single_data", m_data, 64'h5000_0000_0000_0000);
    check_eq("single_last", m_last, 1'b1);
    check_eq("single_err", tdest_err, 1'b0);
    idle(2);

    // Two back-to-back 3-beat packets of all ones
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        drive(64'hFFFF_FFFF_FFFF_FFFF, 4'hA, i == 2);
        s_valid = 1'b1;
        check_eq("ones_valid", m_valid, 1'b1);
        check_eq("ones_data", m_data, (i == 0) ? 64'hD7FF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
    idle(3);

    // TDEST change mid-packet, clear, and clear colliding with a new mismatch
    drive(64'h1234, 4'h3, 1'b0);
    drive(64'h5678, 4'h5, 1'b1);
    check_eq("err_set", tdest_err, 1'b1);
    idle(2);
    check_eq("err_held", tdest_err, 1'b1);
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    check_eq("err_cleared", tdest_err, 1'b0);
    drive(64'h0, 4'h3, 1'b0);
    err_clear = 1'b1;
    drive(64'h0, 4'h6, 1'b1);
    err_clear = 1'b0;
    check_eq("err_set_wins", tdest_err, 1'b1);
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    idle(2);

    // Randomized traffic with varying backpressure and error injection
    rand_traffic(150, 100, 50, 0, 0);
    rand_traffic(200, 70, 60, 10, 5);
    rand_traffic(200, 90, 30, 20, 10);
    rand_traffic(150, 100, 100, 0, 0);

    // Reset mid-packet, after beat 1 of a 4-beat packet
    drive(64'hAAAA, 4'h7, 1'b0);
    drive(64'hBBBB, 4'h7, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", m_valid, 1'b0);
    check_eq("async_rst_ready", s_ready, 1'b0);
    exp_q.delete();
    exp_sop = 1'b1;
    err_exp = 1'b0;
    pkt_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    drive(64'h0, 4'h1, 1'b1);
    check_eq("post_rst_first", m_data, 64'h0800_0000_0000_0000);
    idle(2);

`ifdef TDEST_INSERTER_STATS_EN
    begin
      int lens[5] = '{1, 8, 3, 2, 5};
      err_clear = 1'b1;
      cycle();
      err_clear = 1'b0;
      foreach (lens[p]) begin
        for (int i = 0; i < lens[p]; i++) begin
          drive({$urandom, $urandom}, 4'(p), i == lens[p] - 1);
        end
      end
      idle(3);
      check_eq("stats_five", pkt_cnt, 32'd5);
      force dut.pkt_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_cnt_q;
      pkt_exp = 32'hFFFF_FFFF;
      drive(64'h0, 4'h2, 1'b1);
      idle(2);
      check_eq("stats_wrap", pkt_cnt, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
